// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit ALU datapath.
package alu_pkg;
    localparam int   DATA_W     = 8;
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SLL = 1'b1;
endpackage

// File: rtl/adder_8.sv
// Ripple-carry adder built from 1-bit full-adder stages with no carry-in.
module adder_8
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);
    logic [DATA_W:0] carry;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fa
        assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[DATA_W];
endmodule

// File: rtl/alu_8.sv
// Registered 8-bit ALU: ADD with carry-out or logical left shift, one-cycle latency.
module alu_8
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              aluOp,
    output logic [DATA_W-1:0] out,
    output logic              cout
);
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic [DATA_W-1:0] out_d,  out_q;
    logic              cout_d, cout_q;

    adder_8 u_adder (
        .a    (a),
        .b    (b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Shifter works on a 9-bit {carry,value} vector so the last bit shifted out lands in bit 8.
    logic [DATA_W:0] shift_stage [0:3];
    assign shift_stage[0] = {1'b0, a};

    for (genvar gi = 0; gi < 3; gi++) begin : g_shift
        assign shift_stage[gi + 1] = b[gi]
            ? {shift_stage[gi][DATA_W - (1 << gi):0], {(1 << gi){1'b0}}}
            : shift_stage[gi];
    end

    logic [DATA_W:0] sll_res;

    always_comb begin
        sll_res = '0;
        if (b[7:3] == 5'd0) begin
            sll_res = shift_stage[3];
        end else if (b == 8'd8) begin
            // Shift by exactly 8: only a[0] survives, and it lands in the carry.
            sll_res = {a[0], {DATA_W{1'b0}}};
        end
    end

    always_comb begin
        out_d  = add_sum;
        cout_d = add_cout;
        if (aluOp == ALU_OP_SLL) begin
            out_d  = sll_res[DATA_W-1:0];
            cout_d = sll_res[DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
        end
    end

    assign out  = out_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_alu_8.sv
// Self-checking bench for alu_8: directed vector table, hand sequences and random stream vs. a reference model.
module tb_alu_8;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       aluOp;
    logic [7:0] out;
    logic       cout;

    int checks = 0;
    int errors = 0;

    alu_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .aluOp (aluOp),
        .out   (out),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] exp_out;
        logic       exp_cout;
    } vec_t;

    vec_t vecs [16];

    // Reference: plain integer arithmetic straight from the operation rules.
    function automatic logic [8:0] ref_model(input logic [7:0] ra, input logic [7:0] rb, input logic op);
        int v;
        if (op == 1'b0) begin
            v = int'(ra) + int'(rb);
        end else if (rb == 0) begin
            v = int'(ra);
        end else if (rb <= 8) begin
            v = int'(ra) << int'(rb);
        end else begin
            v = 0;
        end
        return v[8:0];
    endfunction

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic cycle(input logic r, input logic [7:0] ia, input logic [7:0] ib, input logic op);
        rst_n = r; a = ia; b = ib; aluOp = op;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eo, input logic ec);
        checks++;
        if (out !== eo || cout !== ec) begin
            errors++;
            $display("FAIL %s: a=%0d b=%0d op=%0b rst_n=%0b got out=%0d cout=%0b, expected out=%0d cout=%0b",
                     name, a, b, aluOp, rst_n, out, cout, eo, ec);
        end else begin
            $display("ok   %s: a=%0d b=%0d op=%0b rst_n=%0b out=%0d cout=%0b",
                     name, a, b, aluOp, rst_n, out, cout);
        end
    endtask

    initial begin
        logic [8:0] exp;
        logic [7:0] ra, rb;
        logic       rop;
        int         rst_idx;

        vecs[0]  = '{1'b0, 8'd200, 8'd100, 1'b0, 8'd0,   1'b0};
        vecs[1]  = '{1'b0, 8'd200, 8'd100, 1'b0, 8'd0,   1'b0};
        vecs[2]  = '{1'b1, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1};
        vecs[3]  = '{1'b1, 8'd37,  8'd55,  1'b0, 8'd92,  1'b0};
        vecs[4]  = '{1'b1, 8'd255, 8'd1,   1'b0, 8'd0,   1'b1};
        vecs[5]  = '{1'b1, 8'd45,  8'd3,   1'b1, 8'd104, 1'b1};
        vecs[6]  = '{1'b1, 8'h81,  8'd1,   1'b1, 8'h02,  1'b1};
        vecs[7]  = '{1'b1, 8'h12,  8'd0,   1'b1, 8'h12,  1'b0};
        vecs[8]  = '{1'b1, 8'h01,  8'd7,   1'b1, 8'h80,  1'b0};
        vecs[9]  = '{1'b1, 8'h01,  8'd8,   1'b1, 8'h00,  1'b1};
        vecs[10] = '{1'b1, 8'hFF,  8'd9,   1'b1, 8'h00,  1'b0};
        vecs[11] = '{1'b1, 8'hFF,  8'd200, 1'b1, 8'h00,  1'b0};
        vecs[12] = '{1'b1, 8'd10,  8'd20,  1'b0, 8'd30,  1'b0};
        vecs[13] = '{1'b1, 8'd10,  8'd2,   1'b1, 8'd40,  1'b0};
        vecs[14] = '{1'b1, 8'd10,  8'd20,  1'b0, 8'd30,  1'b0};
        vecs[15] = '{1'b1, 8'd10,  8'd2,   1'b1, 8'd40,  1'b0};

        rst_n = 1'b0; a = '0; b = '0; aluOp = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].rst_n, vecs[i].a, vecs[i].b, vecs[i].op);
            check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_cout);
        end

        // Hold a value, then reset while a different op is presented: reset must win.
        cycle(1'b1, 8'd250, 8'd10, 1'b0);
        check("pre_rst", 8'd4, 1'b1);
        cycle(1'b0, 8'd255, 8'd255, 1'b0);
        check("mid_rst", 8'd0, 1'b0);
        cycle(1'b1, 8'd3, 8'd5, 1'b1);
        check("post_rst", 8'd96, 1'b0);

        // Mid-stream reset during 10 ADD then 10 SLL random ops.
        rst_idx = 8 + int'($urandom_range(0, 5));
        for (int i = 0; i < 20; i++) begin
            rop = (i >= 10);
            ra  = rop ? 8'($urandom_range(0, 49)) : 8'($urandom_range(0, 99));
            rb  = rop ? 8'($urandom_range(0, 4))  : 8'($urandom_range(0, 99));
            if (i == rst_idx) begin
                cycle(1'b0, ra, rb, rop);
                check($sformatf("stream%0d_rst", i), 8'd0, 1'b0);
            end else begin
                exp = ref_model(ra, rb, rop);
                cycle(1'b1, ra, rb, rop);
                check($sformatf("stream%0d", i), exp[7:0], exp[8]);
            end
        end

        // Full-range random ops, biasing b toward the shift boundaries.
        for (int i = 0; i < 100; i++) begin
            rop = 1'($urandom);
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            exp = ref_model(ra, rb, rop);
            cycle(1'b1, ra, rb, rop);
            check($sformatf("rand%0d", i), exp[7:0], exp[8]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
